// File: rtl/resize_ctrl_pkg.sv
// Shared types and constants for the camera-to-resizer frame controller.
// Holds the controller state encoding, pixel-count widths and default dimensions.
package resize_ctrl_pkg;

    localparam int DEFAULT_INPUT_WIDTH  = 640;
    localparam int DEFAULT_INPUT_HEIGHT = 480;
    localparam int DEFAULT_OUT_DIM      = 224;

    // Widths sized for the default 640x480 -> 224x224 pipeline.
    localparam int IN_COUNT_W   = 19;
    localparam int OUT_COUNT_W  = 17;
    localparam int DROP_COUNT_W = 16;
    localparam int PIXEL_W      = 24;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ARM    = 3'd1,
        START  = 3'd2,
        STREAM = 3'd3,
        CHECK  = 3'd4
    } ctrlState_t;

    function automatic logic [DROP_COUNT_W-1:0] satIncDrop(input logic [DROP_COUNT_W-1:0] value);
        return (&value) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/resize_frame_ctrl_watchdog.sv
// STREAM-phase watchdog for resize_frame_ctrl; compiled only when
// RESIZE_FRAME_CTRL_TIMEOUT_EN is defined.
`ifdef RESIZE_FRAME_CTRL_TIMEOUT_EN
module frame_watchdog #(
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic clock,
    input  logic resetN,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count;

    // Fires during the TIMEOUT_CYCLES-th enabled cycle so the owner can leave on that edge.
    assign expired = enable && (count == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + 1'b1;
        end
    end

endmodule
`endif

// File: rtl/resize_frame_ctrl.sv
// Gates camera frames into the resizer and checks each resized frame's output count.
// Optional STREAM watchdog enabled by defining RESIZE_FRAME_CTRL_TIMEOUT_EN.
module resize_frame_ctrl
    import resize_ctrl_pkg::*;
#(
    parameter int INPUT_WIDTH    = DEFAULT_INPUT_WIDTH,
    parameter int INPUT_HEIGHT   = DEFAULT_INPUT_HEIGHT,
    parameter int OUT_DIM        = DEFAULT_OUT_DIM,
    parameter int TIMEOUT_CYCLES = 2000000
) (
    input  logic                    clock,
    input  logic                    resetN,
    input  logic                    camFrameStart,
    input  logic                    camPixelValid,
    input  logic [PIXEL_W-1:0]      camPixelData,
    input  logic                    engineReady,
    output logic                    rszStartNewImage,
    output logic                    rszPixelValid,
    output logic [PIXEL_W-1:0]      rszPixelData,
    input  logic                    rszOutPixelValid,
    input  logic                    rszEndOfImage,
    output logic                    frameDone,
    output logic                    frameError,
    output logic [DROP_COUNT_W-1:0] framesDropped,
    output logic                    busy
);

    localparam logic [IN_COUNT_W-1:0]  IN_TOTAL  = IN_COUNT_W'(INPUT_WIDTH * INPUT_HEIGHT);
    localparam logic [OUT_COUNT_W-1:0] OUT_TOTAL = OUT_COUNT_W'(OUT_DIM * OUT_DIM);

    if (TIMEOUT_CYCLES < 1 || INPUT_WIDTH * INPUT_HEIGHT >= (1 << IN_COUNT_W)
        || OUT_DIM * OUT_DIM >= (1 << OUT_COUNT_W)) begin : gParamCheck
        $error("resize_frame_ctrl: parameter out of range");
    end

    ctrlState_t             state;
    logic [IN_COUNT_W-1:0]  inCount;
    logic [OUT_COUNT_W-1:0] outCount;
    logic                   eoiSeen;
    logic                   timeoutHit;

`ifdef RESIZE_FRAME_CTRL_TIMEOUT_EN
    frame_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) uWatchdog (
        .clock  (clock),
        .resetN (resetN),
        .clear  (state != STREAM),
        .enable (state == STREAM),
        .expired(timeoutHit)
    );
`else
    assign timeoutHit = 1'b0;
`endif

    assign busy = (state != IDLE);

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state            <= IDLE;
            inCount          <= '0;
            outCount         <= '0;
            eoiSeen          <= 1'b0;
            rszStartNewImage <= 1'b0;
            rszPixelValid    <= 1'b0;
            rszPixelData     <= '0;
            frameDone        <= 1'b0;
            frameError       <= 1'b0;
            framesDropped    <= '0;
        end else begin
            // NOTE: pulse outputs and the forward strobe default low; only the firing branch raises them.
            rszStartNewImage <= 1'b0;
            rszPixelValid    <= 1'b0;
            frameDone        <= 1'b0;
            frameError       <= 1'b0;

            case (state)
                IDLE: begin
                    if (camFrameStart && !engineReady) framesDropped <= satIncDrop(framesDropped);
                    if (engineReady) state <= ARM;
                end
                ARM: begin
                    if (camFrameStart) begin
                        rszStartNewImage <= 1'b1;
                        state            <= START;
                    end
                end
                START: begin
                    inCount  <= '0;
                    outCount <= '0;
                    eoiSeen  <= 1'b0;
                    if (camFrameStart) begin
                        frameError    <= 1'b1;
                        framesDropped <= satIncDrop(framesDropped);
                        state         <= IDLE;
                    end else begin
                        state <= STREAM;
                    end
                end
                STREAM: begin
                    // A new frame start aborts and swallows any pixel presented alongside it.
                    if (camFrameStart) begin
                        frameError    <= 1'b1;
                        framesDropped <= satIncDrop(framesDropped);
                        state         <= IDLE;
                    end else begin
                        if (rszOutPixelValid && !(&outCount)) outCount <= outCount + 1'b1;
                        if (rszEndOfImage) eoiSeen <= 1'b1;
                        if (inCount == IN_TOTAL) begin
                            state <= CHECK;
                        end else if (timeoutHit) begin
                            frameError <= 1'b1;
                            state      <= IDLE;
                        end else if (camPixelValid) begin
                            rszPixelValid <= 1'b1;
                            rszPixelData  <= camPixelData;
                            inCount       <= inCount + 1'b1;
                        end
                    end
                end
                CHECK: begin
                    frameDone  <= 1'b1;
                    frameError <= (outCount != OUT_TOTAL) || !eoiSeen;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_resize_frame_ctrl.sv
// Self-checking bench for resize_frame_ctrl using a reduced 16x12 -> 8x8 geometry.
module tb_resize_frame_ctrl;

    localparam int W          = 16;
    localparam int H          = 12;
    localparam int OD         = 8;
    localparam int TOTAL      = W * H;
    localparam int OUT_TOTAL  = OD * OD;
    localparam int TB_TIMEOUT = 1000;

    logic        clock = 1'b0;
    logic        resetN;
    logic        camFrameStart;
    logic        camPixelValid;
    logic [23:0] camPixelData;
    logic        engineReady;
    logic        rszStartNewImage;
    logic        rszPixelValid;
    logic [23:0] rszPixelData;
    logic        rszOutPixelValid;
    logic        rszEndOfImage;
    logic        frameDone;
    logic        frameError;
    logic [15:0] framesDropped;
    logic        busy;

    resize_frame_ctrl #(
        .INPUT_WIDTH   (W),
        .INPUT_HEIGHT  (H),
        .OUT_DIM       (OD),
        .TIMEOUT_CYCLES(TB_TIMEOUT)
    ) dut (
        .clock           (clock),
        .resetN          (resetN),
        .camFrameStart   (camFrameStart),
        .camPixelValid   (camPixelValid),
        .camPixelData    (camPixelData),
        .engineReady     (engineReady),
        .rszStartNewImage(rszStartNewImage),
        .rszPixelValid   (rszPixelValid),
        .rszPixelData    (rszPixelData),
        .rszOutPixelValid(rszOutPixelValid),
        .rszEndOfImage   (rszEndOfImage),
        .frameDone       (frameDone),
        .frameError      (frameError),
        .framesDropped   (framesDropped),
        .busy            (busy)
    );

    always #5 clock = ~clock;

    int nAssert   = 0;
    int nFail     = 0;
    int startCnt  = 0;
    int doneCnt   = 0;
    int errCnt    = 0;
    int fwdCnt    = 0;
    int expDrops  = 0;
    logic [23:0] expQ[$];

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        nAssert++;
        assert (observed === expected) else begin
            nFail++;
            $error("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Reference: every forwarded pixel must match the next accepted camera pixel, in order.
    always @(negedge clock) begin
        if (resetN === 1'b1) begin
            if (rszStartNewImage === 1'b1) startCnt++;
            if (frameDone === 1'b1) doneCnt++;
            if (frameError === 1'b1) errCnt++;
            if (rszPixelValid === 1'b1) begin
                fwdCnt++;
                nAssert++;
                assert (expQ.size() > 0) else begin
                    nFail++;
                    $error("FAIL unexpected_pixel: observed data %0h expected no pixel", rszPixelData);
                end
                if (expQ.size() > 0) check("pixel_data", 32'(rszPixelData), 32'(expQ.pop_front()));
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clearInputs();
        camFrameStart    = 1'b0;
        camPixelValid    = 1'b0;
        camPixelData     = '0;
        rszOutPixelValid = 1'b0;
        rszEndOfImage    = 1'b0;
    endtask

    task automatic runFrame(input string tag, input int nOuts, input bit sendEoi,
                            input bit wantErr, input int abortAt, input int resetAt);
        int  s0, d0, e0, f0, outsSent, nPushed;
        bit  cut;
        s0 = startCnt; d0 = doneCnt; e0 = errCnt; f0 = fwdCnt;
        outsSent = 0; nPushed = 0; cut = 1'b0;

        engineReady = 1'b1; tick();
        engineReady = 1'b0; camFrameStart = 1'b1; tick();
        camFrameStart = 1'b0;
        check({tag, "_start_pulse"}, 32'(rszStartNewImage), 1);
        camPixelValid = 1'b1; camPixelData = 24'($urandom); tick();

        for (int i = 0; i < TOTAL && !cut; i++) begin
            if (i > 0) begin
                while ($urandom_range(3) == 0) begin
                    camPixelValid = 1'b0; rszOutPixelValid = 1'b0; rszEndOfImage = 1'b0;
                    tick();
                end
            end
            camPixelValid    = 1'b1;
            camPixelData     = 24'($urandom);
            rszOutPixelValid = (outsSent < nOuts);
            if (rszOutPixelValid) outsSent++;
            rszEndOfImage    = sendEoi && rszOutPixelValid && (outsSent == nOuts);
            if (i == resetAt) begin
                #2 resetN = 1'b0;
                #1;
                check({tag, "_rst_data"}, 32'(rszPixelData), 0);
                check({tag, "_rst_ctrl"}, 32'({rszStartNewImage, rszPixelValid, frameDone, frameError, busy}), 0);
                check({tag, "_rst_drops"}, 32'(framesDropped), 0);
                clearInputs();
                tick(); tick();
                #2 resetN = 1'b1;
                expQ.delete();
                expDrops = 0;
                tick();
                check({tag, "_rst_no_done"}, 32'(doneCnt - d0), 0);
                check({tag, "_rst_no_err"}, 32'(errCnt - e0), 0);
                return;
            end
            if (i == abortAt) begin
                camFrameStart = 1'b1;
                cut = 1'b1;
            end else begin
                expQ.push_back(camPixelData);
                nPushed++;
            end
            tick();
            camFrameStart = 1'b0;
            if (i == 0 && !cut) begin
                check({tag, "_first_latency"}, 32'(rszPixelValid), 1);
                check({tag, "_busy_stream"}, 32'(busy), 1);
            end
        end

        clearInputs();
        repeat (5) tick();

        check({tag, "_starts"}, 32'(startCnt - s0), 1);
        check({tag, "_forwarded"}, 32'(fwdCnt - f0), 32'(nPushed));
        check({tag, "_queue_empty"}, 32'(expQ.size()), 0);
        check({tag, "_busy_after"}, 32'(busy), 0);
        if (abortAt >= 0) begin
            expDrops++;
            check({tag, "_err"}, 32'(errCnt - e0), 1);
            check({tag, "_done"}, 32'(doneCnt - d0), 0);
        end else begin
            check({tag, "_pixels"}, 32'(nPushed), TOTAL);
            check({tag, "_done"}, 32'(doneCnt - d0), 1);
            check({tag, "_err"}, 32'(errCnt - e0), 32'(wantErr));
        end
        check({tag, "_drops"}, 32'(framesDropped), 32'(expDrops));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: observed no finish expected finish");
        $fatal(1, "bench time limit reached");
    end

    initial begin
        int f0, e0, d0, cyc;
        clearInputs();
        engineReady = 1'b0;
        resetN = 1'b0;
        repeat (3) tick();
        check("reset_data", 32'(rszPixelData), 0);
        check("reset_ctrl", 32'({rszStartNewImage, rszPixelValid, frameDone, frameError, busy}), 0);
        check("reset_drops", 32'(framesDropped), 0);
        resetN = 1'b1;
        tick();

        runFrame("good", OUT_TOTAL, 1'b1, 1'b0, -1, -1);

        f0 = fwdCnt;
        for (int k = 0; k < 3; k++) begin
            camFrameStart = 1'b1; camPixelValid = 1'b1; camPixelData = 24'($urandom);
            tick();
            camFrameStart = 1'b0;
            tick();
        end
        clearInputs();
        expDrops += 3;
        tick();
        check("idle_drops", 32'(framesDropped), 32'(expDrops));
        check("idle_no_forward", 32'(fwdCnt - f0), 0);
        check("idle_busy", 32'(busy), 0);

        runFrame("short", OUT_TOTAL - 1, 1'b1, 1'b1, -1, -1);
        runFrame("no_eoi", OUT_TOTAL, 1'b0, 1'b1, -1, -1);
        runFrame("long", OUT_TOTAL + 1, 1'b1, 1'b1, -1, -1);
        runFrame("abort", OUT_TOTAL, 1'b1, 1'b0, 50, -1);
        runFrame("reset", OUT_TOTAL, 1'b1, 1'b0, -1, 40);
        runFrame("after_reset", OUT_TOTAL, 1'b1, 1'b0, -1, -1);
        runFrame("good2", OUT_TOTAL, 1'b1, 1'b0, -1, -1);

`ifdef RESIZE_FRAME_CTRL_TIMEOUT_EN
        engineReady = 1'b1; tick();
        engineReady = 1'b0; camFrameStart = 1'b1; tick();
        camFrameStart = 1'b0;
        e0 = errCnt; d0 = doneCnt; cyc = 0;
        while (errCnt == e0 && cyc < TB_TIMEOUT + 20) begin
            tick();
            cyc++;
        end
        check("timeout_err", 32'(errCnt - e0), 1);
        check("timeout_cycle_window", 32'(cyc >= TB_TIMEOUT && cyc <= TB_TIMEOUT + 3), 1);
        tick();
        check("timeout_no_done", 32'(doneCnt - d0), 0);
        check("timeout_drops", 32'(framesDropped), 32'(expDrops));
        check("timeout_busy", 32'(busy), 0);
`else
        e0 = 0; d0 = 0; cyc = 0;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule

// File: doc/resize_frame_ctrl.md
RESIZE_FRAME_CTRL -- requirements
Module: resize_frame_ctrl

Interface
REQ-001 SHALL have parameter INPUT_WIDTH, default 640: camera pixels per row.
REQ-002 SHALL have parameter INPUT_HEIGHT, default 480: camera rows per frame.
REQ-003 SHALL have parameter OUT_DIM, default 224: resizer output side; expected output pixels = OUT_DIM*OUT_DIM.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 2000000: watchdog limit (see Configuration).
REQ-005 SHALL have one clock and an asynchronous, active-low reset; ports: clock input 1 (rising-edge clock); resetN input 1 (async active-low reset).
REQ-006 SHALL have ports, each as name, direction, width, meaning:
- camFrameStart, input, 1: one-cycle camera frame-start pulse.
- camPixelValid, input, 1: camera pixel strobe.
- camPixelData, input, 24: camera pixel {B,G,R}.
- engineReady, input, 1: downstream inference engine can accept a frame.
- rszStartNewImage, output, 1: start pulse to resizer.
- rszPixelValid, output, 1: gated pixel strobe to resizer.
- rszPixelData, output, 24: pixel to resizer.
- rszOutPixelValid, input, 1: resizer output strobe.
- rszEndOfImage, input, 1: resizer end-of-image pulse.
- frameDone, output, 1: one-cycle frame-complete pulse.
- frameError, output, 1: one-cycle error pulse, coincident with frameDone or abort.
- framesDropped, output, 16: saturating dropped-frame count.
- busy, output, 1: high in any state other than IDLE.

Function
REQ-007 SHALL implement states IDLE, ARM, START, STREAM, CHECK.
REQ-008 IDLE: SHALL go to ARM when engineReady=1. A camFrameStart seen in IDLE with engineReady=0 SHALL increment framesDropped, saturating at 65535.
REQ-009 ARM: SHALL go to START on camFrameStart. Pixels arriving in IDLE/ARM SHALL NOT be forwarded.
REQ-010 START: SHALL assert rszStartNewImage for exactly one cycle, clear inCount, outCount and eoiSeen, and go to STREAM.
REQ-011 STREAM: SHALL forward camPixelValid/camPixelData to rszPixelValid/rszPixelData through one register stage (1-cycle latency) and increment inCount per valid pixel.
REQ-012 STREAM: SHALL count rszOutPixelValid into outCount (17 bits, saturating) and set eoiSeen on rszEndOfImage.
REQ-013 STREAM: when inCount reaches INPUT_WIDTH*INPUT_HEIGHT, SHALL stop forwarding, drain the register stage, and go to CHECK.
REQ-014 CHECK: SHALL pulse frameDone for one cycle, with frameError=1 iff outCount != OUT_DIM*OUT_DIM or eoiSeen=0, then go to IDLE.
REQ-015 camFrameStart during START or STREAM SHALL abort: pulse frameError (no frameDone), increment framesDropped, and go to IDLE.
REQ-016 rszEndOfImage and rszOutPixelValid in the same cycle SHALL both be counted.
REQ-017 The final pixel accepted in the same cycle as an abort SHALL NOT be forwarded.

Reset
REQ-018 On resetN=0 SHALL go to IDLE asynchronously and zero all outputs, counters, eoiSeen and the forward register.
REQ-019 Reset mid-STREAM SHALL NOT produce frameDone or frameError pulses.

Configuration
REQ-020 With macro RESIZE_FRAME_CTRL_TIMEOUT_EN defined, SHALL count cycles in STREAM. On reaching TIMEOUT_CYCLES without completion, SHALL pulse frameError and go to IDLE, with framesDropped unchanged.
REQ-021 Without RESIZE_FRAME_CTRL_TIMEOUT_EN, SHALL contain no watchdog logic, and STREAM waits indefinitely.

Structure
REQ-022 Shared package resize_ctrl_pkg SHALL hold the state enum typedef, the pixel-count widths and the default dimension constants.
REQ-023 The watchdog SHALL be a sub-module frame_watchdog (clear, enable, expired), instantiated only under the macro.

Verification
REQ-024 engineReady=1, full 640x480 frame, resizer returns 50176 outputs plus EOI -> one rszStartNewImage pulse, 307200 forwarded pixels, frameDone=1, frameError=0.
REQ-025 engineReady=0, three camFrameStart pulses -> framesDropped=3, rszPixelValid never asserted.
REQ-026 Resizer returns 50175 outputs -> frameDone=1 with frameError=1.
REQ-027 camFrameStart after 1000 streamed pixels -> frameError pulse, no frameDone, framesDropped+1, state IDLE.
REQ-028 resetN low at pixel 5000 -> all outputs 0 immediately; after release, the next frame completes normally.
REQ-029 With the macro defined and TIMEOUT_CYCLES=100, stall pixels after START -> frameError at cycle 100, then IDLE.
